// File: rtl/mlp_out_axi_writer_if.sv
// mlp_out_axi_writer_if: AXI4 bundle (t_AXI4) shared by the MLP output writer and its memory-side peer.
interface t_AXI4 #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 42,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_WIDTH-1:0]    awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [LEN_WIDTH-1:0]    arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;
  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );
endinterface

// File: rtl/mlp_out_axi_writer.sv
// mlp_out_axi_writer: packs the MLP result stream into AXI4 INCR write bursts toward external memory.
// Optional MLP_AXI_WR_PERF_EN adds busy-cycle and AW-stall performance counters.
module mlp_out_axi_writer #(
  parameter int DATA_WIDTH      = 256,
  parameter int ADDR_WIDTH      = 42,
  parameter int LEN_WIDTH       = 8,
  parameter int BURST_LEN       = 16,
  parameter int FIFO_DEPTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_WIDTH        = 4,
  parameter logic [ID_WIDTH-1:0] AXI_ID = '0
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [31:0]           i_num_beats,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_bresp_err,
  t_AXI4.master                 axi_if
`ifdef MLP_AXI_WR_PERF_EN
  ,
  output logic [31:0]           o_perf_busy_cyc,
  output logic [31:0]           o_perf_aw_stall
`endif
);
  localparam int BPB = DATA_WIDTH / 8;
  localparam int SZ  = $clog2(BPB);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~(ADDR_WIDTH'(BPB * BURST_LEN - 1));
  typedef enum logic [1:0] {S_IDLE, S_AW, S_W, S_FLUSH} state_t;
  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           num_q, in_q, rem_q, blen;
  logic [LEN_WIDTH-1:0]  len_q, bcnt_q;
  logic [OW-1:0]         out_q;
  logic [PW-1:0]         wp_q, rp_q;
  logic [PW:0]           cnt_q;
  logic                  done_q, err_q;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  push, pop, aw_hs, b_hs;
  logic                  unused_ok;
  assign blen   = (rem_q > 32'(BURST_LEN)) ? 32'(BURST_LEN) : rem_q;
  assign o_busy = state_q != S_IDLE;
  assign o_ready = o_busy & (cnt_q != (PW+1)'(FIFO_DEPTH)) & (in_q < num_q);
  assign o_done = done_q;
  assign o_bresp_err = err_q;
  assign push  = i_valid & o_ready;
  assign pop   = axi_if.wvalid & axi_if.wready;
  assign aw_hs = axi_if.awvalid & axi_if.awready;
  assign b_hs  = axi_if.bvalid & axi_if.bready;
  // AW waits for a whole burst to be buffered so W never stalls mid-burst on input
  assign axi_if.awvalid  = (state_q == S_AW) & (out_q < OW'(MAX_OUTSTANDING)) & (32'(cnt_q) >= blen);
  assign axi_if.awaddr   = addr_q;
  assign axi_if.awlen    = LEN_WIDTH'(blen - 32'd1);
  assign axi_if.awid     = AXI_ID;
  assign axi_if.awsize   = 3'(SZ);
  assign axi_if.awburst  = 2'b01;
  assign axi_if.awlock   = 1'b0;
  assign axi_if.awcache  = '0;
  assign axi_if.awprot   = '0;
  assign axi_if.awqos    = '0;
  assign axi_if.awregion = '0;
  assign axi_if.wvalid   = (state_q == S_W) & (cnt_q != '0);
  assign axi_if.wdata    = mem[rp_q];
  assign axi_if.wstrb    = '1;
  assign axi_if.wlast    = bcnt_q == len_q;
  assign axi_if.bready   = o_busy;
  assign axi_if.arid     = '0;
  assign axi_if.araddr   = '0;
  assign axi_if.arlen    = '0;
  assign axi_if.arsize   = '0;
  assign axi_if.arburst  = '0;
  assign axi_if.arlock   = 1'b0;
  assign axi_if.arcache  = '0;
  assign axi_if.arprot   = '0;
  assign axi_if.arqos    = '0;
  assign axi_if.arregion = '0;
  assign axi_if.arvalid  = 1'b0;
  assign axi_if.rready   = 1'b1;
  assign unused_ok = ^{axi_if.bid, axi_if.arready, axi_if.rid, axi_if.rdata, axi_if.rresp,
                       axi_if.rlast, axi_if.rvalid};
  always_ff @(posedge i_clk)
    if (push) mem[wp_q] <= i_data;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      num_q   <= '0;
      in_q    <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      bcnt_q  <= '0;
      out_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
      out_q  <= out_q + OW'(aw_hs) - OW'(b_hs);
      if (push) wp_q <= wp_q + 1'b1;
      if (push) in_q <= in_q + 32'd1;
      if (pop) rp_q <= rp_q + 1'b1;
      if (b_hs && axi_if.bresp != 2'b00) err_q <= 1'b1;
      case (state_q)
        S_IDLE: if (i_start) begin
          addr_q  <= i_base_addr & AMASK;
          num_q   <= i_num_beats;
          rem_q   <= i_num_beats;
          in_q    <= '0;
          err_q   <= 1'b0;
          state_q <= (i_num_beats == '0) ? S_FLUSH : S_AW;
        end
        S_AW: if (aw_hs) begin
          addr_q  <= addr_q + (ADDR_WIDTH'(blen) << SZ);
          rem_q   <= rem_q - blen;
          len_q   <= axi_if.awlen;
          bcnt_q  <= '0;
          state_q <= S_W;
        end
        S_W: if (pop) begin
          bcnt_q <= bcnt_q + 1'b1;
          if (axi_if.wlast) state_q <= (rem_q != '0) ? S_AW : S_FLUSH;
        end
        S_FLUSH: if (out_q == '0) begin
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end
`ifdef MLP_AXI_WR_PERF_EN
  logic [31:0] busy_cyc_q, stall_q;
  assign o_perf_busy_cyc = busy_cyc_q;
  assign o_perf_aw_stall = stall_q;
  always_ff @(posedge i_clk) begin
    if (i_reset || (!o_busy && i_start)) begin
      busy_cyc_q <= '0;
      stall_q    <= '0;
    end else begin
      if (o_busy && busy_cyc_q != '1) busy_cyc_q <= busy_cyc_q + 32'd1;
      if (axi_if.awvalid && !axi_if.awready && stall_q != '1) stall_q <= stall_q + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mlp_out_axi_writer.sv
// tb_mlp_out_axi_writer: directed and randomized jobs against a burst-level reference of the writer.
module tb_mlp_out_axi_writer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, start, valid, ready, busy, done, berr;
  logic [41:0] base;
  logic [31:0] nb;
  logic [255:0] data;
  int checks = 0, failures = 0;
  t_AXI4 #(.DATA_WIDTH(256), .ADDR_WIDTH(42), .LEN_WIDTH(8)) axi();
`ifdef MLP_AXI_WR_PERF_EN
  logic [31:0] perf_busy, perf_stall;
`endif
  mlp_out_axi_writer #(.DATA_WIDTH(256), .ADDR_WIDTH(42), .LEN_WIDTH(8), .BURST_LEN(16),
                       .FIFO_DEPTH(32), .MAX_OUTSTANDING(4)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_base_addr(base), .i_num_beats(nb),
    .i_data(data), .i_valid(valid), .o_ready(ready), .o_busy(busy), .o_done(done),
    .o_bresp_err(berr), .axi_if(axi)
`ifdef MLP_AXI_WR_PERF_EN
    , .o_perf_busy_cyc(perf_busy), .o_perf_aw_stall(perf_stall)
`endif
  );
  logic [255:0] feed[$];
  logic [41:0]  aw_a[$];
  logic [7:0]   aw_l[$];
  int           aw_cyc[$], b_cyc[$];
  logic [255:0] w_d[$];
  bit           w_l[$];
  int fidx = 0, b_tok = 0, b_pend = 0, b_idx = 0, err_idx = -1;
  int done_n = 0, out_now = 0, out_max = 0, cyc = 0;
  bit rnd = 0, b_hold = 0, in_hs = 0, ready_seen = 0;
  // Memory-side agent and input feeder: drives at negedge, logs handshakes due at the next posedge
  initial begin
    valid = 0; data = '0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bresp = 0; axi.bid = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = 0; axi.rdata = 0; axi.rresp = 0; axi.rlast = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (done) done_n++;
      if (ready) ready_seen = 1;
      if (in_hs) fidx++;
      if (rst) begin
        valid = 0; axi.bvalid = 0; b_pend = 0; in_hs = 0; out_now = 0;
        continue;
      end
      valid = fidx < feed.size() && (!rnd || $urandom_range(3) != 0);
      data = valid ? feed[fidx] : '0;
      axi.awready = !rnd || $urandom_range(1) == 1;
      axi.wready = !rnd || $urandom_range(3) != 0;
      axi.bvalid = b_pend > 0 && (b_hold ? b_tok > 0 : (!rnd || $urandom_range(1) == 1));
      axi.bresp = (b_idx == err_idx) ? 2'b10 : 2'b00;
      in_hs = valid && ready;
      if (axi.awvalid && axi.awready) begin
        aw_a.push_back(axi.awaddr); aw_l.push_back(axi.awlen); aw_cyc.push_back(cyc); out_now++;
      end
      if (axi.bvalid && axi.bready) begin
        b_cyc.push_back(cyc); b_pend--; b_idx++; out_now--;
        if (b_hold) b_tok--;
      end
      if (axi.wvalid && axi.wready) begin
        w_d.push_back(axi.wdata); w_l.push_back(axi.wlast);
        if (axi.wlast) b_pend++;
      end
      if (out_now > out_max) out_max = out_now;
    end
  end
  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic clear_mon();
    aw_a.delete(); aw_l.delete(); aw_cyc.delete(); b_cyc.delete(); w_d.delete(); w_l.delete();
    done_n = 0; ready_seen = 0; b_idx = 0; out_max = 0;
  endtask
  task automatic launch(logic [41:0] b, int n, bit r);
    feed.delete();
    fidx = 0;
    for (int i = 0; i < n; i++) feed.push_back({8{$urandom}});
    rnd = r; base = b; nb = n; start = 1;
    step(1);
    start = 0;
  endtask
  task automatic wait_done(string t, int lim);
    int k = 0;
    while (done_n == 0 && k < lim) begin step(1); k++; end
    chk({t, "_done_seen"}, done_n != 0, 1);
    step(2);
  endtask
  // Reference: bursts of min(16, remaining) beats from the 512-byte-aligned base, 32 bytes per beat
  task automatic check_job(string t, logic [41:0] b, int n);
    logic [41:0] a = b & ~42'h1FF;
    int rem = n, k = 0, bl;
    chk({t, "_aw_cnt"}, aw_a.size(), (n + 15) / 16);
    while (rem > 0) begin
      bl = rem > 16 ? 16 : rem;
      if (k < aw_a.size()) begin
        chk({t, "_awaddr"}, aw_a[k], a);
        chk({t, "_awlen"}, aw_l[k], bl - 1);
      end
      a = a + 42'(bl * 32); rem -= bl; k++;
    end
    chk({t, "_w_cnt"}, w_d.size(), n);
    for (int j = 0; j < w_d.size() && j < n; j++) begin
      chk({t, "_wdata"}, w_d[j], feed[j]);
      chk({t, "_wlast"}, w_l[j], (j % 16 == 15) || (j == n - 1));
    end
    chk({t, "_done_cnt"}, done_n, 1);
    chk({t, "_out_le_max"}, out_max <= 4, 1);
  endtask
  initial begin
    int k;
    logic [41:0] rb;
    int rn;
    rst = 1; start = 0; base = '0; nb = '0;
    step(3);
    chk("rst_busy", busy, 0);
    chk("rst_ready", ready, 0);
    chk("rst_done", done, 0);
    chk("rst_berr", berr, 0);
    chk("rst_awvalid", axi.awvalid, 0);
    chk("rst_wvalid", axi.wvalid, 0);
    chk("arvalid", axi.arvalid, 0);
    chk("rready", axi.rready, 1);
    chk("awsize", axi.awsize, 3'b101);
    chk("awburst", axi.awburst, 2'b01);
    chk("wstrb", axi.wstrb, {32{1'b1}});
    rst = 0;
    step(1);
    clear_mon(); launch(42'h1000, 64, 0); wait_done("t1", 2000); check_job("t1", 42'h1000, 64);
    chk("t1_berr", berr, 0);
    clear_mon(); launch(42'h2000, 20, 1); wait_done("t2", 2000); check_job("t2", 42'h2000, 20);
    clear_mon(); b_hold = 1; b_tok = 0; launch(42'h3000, 128, 0);
    step(200);
    chk("t3_aw_at_max", aw_a.size(), 4);
    chk("t3_awvalid_held", axi.awvalid, 0);
    chk("t3_busy", busy, 1);
    b_tok = 1;
    step(5);
    chk("t3_aw_after_b", aw_a.size(), 5);
    chk("t3_aw5_delay", (aw_cyc.size() > 4 && b_cyc.size() > 0) ? aw_cyc[4] - b_cyc[0] : -1, 1);
    step(50);
    chk("t3_aw_refull", aw_a.size(), 5);
    chk("t3_awvalid_refull", axi.awvalid, 0);
    b_hold = 0;
    wait_done("t3", 4000); check_job("t3", 42'h3000, 128);
    chk("t3_out_max", out_max, 4);
    clear_mon(); err_idx = 1; launch(42'h4000, 32, 1); wait_done("t4", 2000); check_job("t4", 42'h4000, 32);
    chk("t4_berr", berr, 1);
    step(5);
    chk("t4_berr_sticky", berr, 1);
    err_idx = -1;
    clear_mon(); launch(42'h5000, 32, 0);
    chk("t4_berr_cleared", berr, 0);
    k = 0;
    while (w_d.size() < 5 && k < 500) begin step(1); k++; end
    chk("t5_reach_beat5", w_d.size() >= 5, 1);
    rst = 1;
    step(1);
    chk("t5_awvalid", axi.awvalid, 0);
    chk("t5_wvalid", axi.wvalid, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", ready, 0);
    rst = 0;
    step(1);
    clear_mon(); launch(42'h8000, 16, 1); wait_done("t5b", 2000); check_job("t5b", 42'h8000, 16);
    clear_mon(); launch(42'h6000, 0, 0); wait_done("t6", 3); check_job("t6", 42'h6000, 0);
    chk("t6_ready_never", ready_seen, 0);
    clear_mon(); b_hold = 1; b_tok = 0; launch(42'hA000, 16, 0);
    step(3);
    base = 42'hB000; nb = 4; start = 1;
    step(1);
    start = 0;
    step(50);
    b_hold = 0;
    wait_done("t6b", 2000); check_job("t6b", 42'hA000, 16);
    for (int i = 0; i < 3; i++) begin
      rb = {$urandom, $urandom};
      rb[41:40] = 2'b00;
      rn = $urandom_range(60, 1);
      clear_mon(); launch(rb, rn, 1); wait_done("t7", 3000); check_job("t7", rb, rn);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
